// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch resolution for beq/bne.
// Sequences the equality comparator and waits out EX/MEM operand hazards by stalling the front end.
// Selects comparator forwarding, redirects the PC and flushes IF/ID on a taken branch.
// Keeps saturating branch/taken/stall statistics.
module branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_beq,
  input  logic        id_bne,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  input  logic        kill,
  input  logic        cmp_zero,
  output logic        cmp_en,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        stall,
  output logic        flush,
  output logic        pc_src,
  output logic [15:0] br_count,
  output logic [15:0] taken_count,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

  state_t     state, state_nxt;
  logic [1:0] scnt, scnt_nxt;
  logic [1:0] need;
  logic       br_present;
  logic       resolve;
  logic       taken;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // A producer hazards the branch when it writes a non-zero register the branch reads.
  function automatic logic hz_match(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return (rd != 5'd0) && ((rd == rs) || (rd == rt));
  endfunction

  // Outputs are gated by rst_n so that an asserted reset forces every control output low at once.
  assign br_present = rst_n & id_valid & (id_beq | id_bne) & ~kill;

  // Number of stall cycles needed before the comparator operands are available.
  always_comb begin
    need = 2'd0;
    if (mem_regwrite && mem_memread && hz_match(mem_rd, id_rs, id_rt))
      need = 2'd1;
    if (ex_regwrite && !ex_memread && hz_match(ex_rd, id_rs, id_rt))
      need = 2'd1;
    if (ex_regwrite && ex_memread && hz_match(ex_rd, id_rs, id_rt))
      need = 2'd2;
  end

  // Next-state and Mealy control outputs; kill overrides everything.
  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    stall     = 1'b0;
    resolve   = 1'b0;
    case (state)
      IDLE: begin
        if (br_present) begin
          if (need == 2'd0) begin
            resolve = 1'b1;
          end else begin
            stall     = 1'b1;
            scnt_nxt  = need - 2'd1;
            state_nxt = (need == 2'd2) ? STALL : RESOLVE;
          end
        end
      end
      STALL: begin
        if (br_present) begin
          stall     = 1'b1;
          scnt_nxt  = scnt - 2'd1;
          state_nxt = (scnt == 2'd1) ? RESOLVE : STALL;
        end else begin
          // The held branch vanished without a kill; abandon it.
          state_nxt = IDLE;
          scnt_nxt  = 2'd0;
        end
      end
      RESOLVE: begin
        resolve   = br_present;
        state_nxt = IDLE;
        scnt_nxt  = 2'd0;
      end
      default: begin
        state_nxt = IDLE;
        scnt_nxt  = 2'd0;
      end
    endcase
    if (kill) begin
      state_nxt = IDLE;
      scnt_nxt  = 2'd0;
    end
  end

  // Resolve outputs: comparator strobe, forwarding selects and taken-branch redirect.
  always_comb begin
    taken  = resolve & (id_beq ? cmp_zero : ~cmp_zero);
    cmp_en = resolve;
    pc_src = taken;
    flush  = taken;
    fwd_a  = resolve & mem_regwrite & ~mem_memread & (mem_rd != 5'd0) & (mem_rd == id_rs);
    fwd_b  = resolve & mem_regwrite & ~mem_memread & (mem_rd != 5'd0) & (mem_rd == id_rt);
  end

  // State register and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      scnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count    <= 16'd0;
      taken_count <= 16'd0;
      stall_count <= 16'd0;
    end else begin
      br_count    <= sat_inc(br_count, resolve);
      taken_count <= sat_inc(taken_count, taken);
      stall_count <= sat_inc(stall_count, stall);
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus randomized traffic against a stall-countdown model.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, id_beq = 1'b0, id_bne = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0;
  logic        ex_regwrite = 1'b0, ex_memread = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        mem_regwrite = 1'b0, mem_memread = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic        kill = 1'b0, cmp_zero = 1'b0;
  logic        cmp_en, fwd_a, fwd_b, stall, flush, pc_src;
  logic [15:0] br_count, taken_count, stall_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: is a branch waiting, and how many more stall cycles it owes.
  bit m_pend;
  int m_left;
  int m_br, m_tk, m_st;

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_beq(id_beq), .id_bne(id_bne),
    .id_rs(id_rs), .id_rt(id_rt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .kill(kill), .cmp_zero(cmp_zero), .cmp_en(cmp_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .flush(flush), .pc_src(pc_src), .br_count(br_count),
    .taken_count(taken_count), .stall_count(stall_count)
  );

  // Observed control outputs packed as {stall, cmp_en, fwd_a, fwd_b, pc_src, flush}.
  function automatic logic [5:0] ctl();
    return {stall, cmp_en, fwd_a, fwd_b, pc_src, flush};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_beq = 0; id_bne = 0; id_rs = 0; id_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    kill = 0; cmp_zero = 0;
  endtask

  task automatic set_br(input bit beq, input logic [4:0] rs, input logic [4:0] rt);
    id_valid = 1; id_beq = beq; id_bne = !beq; id_rs = rs; id_rt = rt;
  endtask

  task automatic set_ex(input bit rw, input bit mr, input logic [4:0] rd);
    ex_regwrite = rw; ex_memread = mr; ex_rd = rd;
  endtask

  task automatic set_mem(input bit rw, input bit mr, input logic [4:0] rd);
    mem_regwrite = rw; mem_memread = mr; mem_rd = rd;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    set_idle();
    m_pend = 0; m_left = 0; m_br = 0; m_tk = 0; m_st = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_br(1, 5'd1, 5'd2);
    cmp_zero = 1;
    #2;
    vectors++;
    if (ctl() !== 6'b000000) begin
      miscompares++; $display("FAIL reset_ctl: got %b want 000000", ctl());
    end
    vectors++;
    if ({br_count, taken_count, stall_count} !== 48'd0) begin
      miscompares++; $display("FAIL reset_cnt: got %h %h %h want 0", br_count, taken_count, stall_count);
    end
    do_reset();
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_br(1, 5'd1, 5'd2); cmp_zero = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b010011) begin
      miscompares++; $display("FAIL nohaz_ctl: got %b want 010011", ctl());
    end
    tick(); set_idle();
    @(negedge clk);
    vectors++;
    if ({br_count, taken_count, stall_count} !== {16'd1, 16'd1, 16'd0}) begin
      miscompares++; $display("FAIL nohaz_cnt: got %0d %0d %0d want 1 1 0", br_count, taken_count, stall_count);
    end
    tick();
  endtask

  task automatic test_alu_hazard();
    do_reset();
    set_ex(1, 0, 5'd3); set_br(0, 5'd3, 5'd4); cmp_zero = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b100000) begin
      miscompares++; $display("FAIL alu_stall: got %b want 100000", ctl());
    end
    tick();
    set_ex(0, 0, 5'd0); set_mem(1, 0, 5'd3);
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b011000) begin
      miscompares++; $display("FAIL alu_resolve: got %b want 011000", ctl());
    end
    tick(); set_idle();
    @(negedge clk);
    vectors++;
    if ({br_count, taken_count, stall_count} !== {16'd1, 16'd0, 16'd1}) begin
      miscompares++; $display("FAIL alu_cnt: got %0d %0d %0d want 1 0 1", br_count, taken_count, stall_count);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_ex(1, 1, 5'd5); set_br(1, 5'd0, 5'd5); cmp_zero = 0;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b100000) begin
      miscompares++; $display("FAIL load_stall1: got %b want 100000", ctl());
    end
    tick();
    set_ex(0, 0, 5'd0); set_mem(1, 1, 5'd5);
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b100000) begin
      miscompares++; $display("FAIL load_stall2: got %b want 100000", ctl());
    end
    tick();
    set_mem(0, 0, 5'd0);
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b010000) begin
      miscompares++; $display("FAIL load_resolve: got %b want 010000", ctl());
    end
    tick(); set_idle();
    @(negedge clk);
    vectors++;
    if ({br_count, taken_count, stall_count} !== {16'd1, 16'd0, 16'd2}) begin
      miscompares++; $display("FAIL load_cnt: got %0d %0d %0d want 1 0 2", br_count, taken_count, stall_count);
    end
    tick();
  endtask

  task automatic test_kill_mid_stall();
    do_reset();
    set_ex(1, 1, 5'd6); set_br(1, 5'd6, 5'd1); cmp_zero = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b100000) begin
      miscompares++; $display("FAIL kill_stall1: got %b want 100000", ctl());
    end
    tick();
    set_ex(0, 0, 5'd0); kill = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b000000) begin
      miscompares++; $display("FAIL kill_ctl: got %b want 000000", ctl());
    end
    tick();
    set_idle();
    set_br(1, 5'd1, 5'd2); cmp_zero = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b010011) begin
      miscompares++; $display("FAIL kill_then_idle: got %b want 010011", ctl());
    end
    vectors++;
    if ({br_count, stall_count} !== {16'd0, 16'd1}) begin
      miscompares++; $display("FAIL kill_cnt: got br %0d st %0d want 0 1", br_count, stall_count);
    end
    tick(); set_idle();
  endtask

  task automatic test_kill_priority();
    do_reset();
    set_br(1, 5'd1, 5'd2); cmp_zero = 1; kill = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b000000) begin
      miscompares++; $display("FAIL killprio_ctl: got %b want 000000", ctl());
    end
    tick(); set_idle();
    @(negedge clk);
    vectors++;
    if (br_count !== 16'd0) begin
      miscompares++; $display("FAIL killprio_cnt: got %0d want 0", br_count);
    end
    tick();
  endtask

  task automatic test_r0();
    do_reset();
    set_ex(1, 1, 5'd0); set_mem(1, 1, 5'd0); set_br(1, 5'd0, 5'd0); cmp_zero = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b010011) begin
      miscompares++; $display("FAIL r0_ctl: got %b want 010011", ctl());
    end
    tick(); set_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_br(1, 5'd1, 5'd2); cmp_zero = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b010011) begin
      miscompares++; $display("FAIL b2b_1: got %b want 010011", ctl());
    end
    tick();
    set_br(0, 5'd1, 5'd2); cmp_zero = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b010000) begin
      miscompares++; $display("FAIL b2b_2: got %b want 010000", ctl());
    end
    tick();
    set_ex(1, 0, 5'd7); set_br(0, 5'd7, 5'd1); cmp_zero = 0;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b100000) begin
      miscompares++; $display("FAIL b2b_3: got %b want 100000", ctl());
    end
    tick();
    set_ex(0, 0, 5'd0);
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b010011) begin
      miscompares++; $display("FAIL b2b_4: got %b want 010011", ctl());
    end
    tick();
    set_br(1, 5'd1, 5'd2); cmp_zero = 1;
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b010011) begin
      miscompares++; $display("FAIL b2b_5: got %b want 010011", ctl());
    end
    tick(); set_idle();
    @(negedge clk);
    vectors++;
    if ({br_count, taken_count, stall_count} !== {16'd4, 16'd3, 16'd1}) begin
      miscompares++; $display("FAIL b2b_cnt: got %0d %0d %0d want 4 3 1", br_count, taken_count, stall_count);
    end
    tick();
  endtask

  function automatic bit reads(input logic [4:0] rd);
    return rd != 0 && (rd == id_rs || rd == id_rt);
  endfunction

  task automatic test_random();
    bit          bp, res, stl, tk, fa, fb;
    int          n;
    logic [5:0]  exp;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!m_pend) begin
        id_valid = ($urandom_range(0, 3) != 0);
        n = $urandom_range(0, 2);
        id_beq = (n == 1); id_bne = (n == 2);
        id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      end
      ex_regwrite = 1'($urandom_range(0, 1)); ex_memread = 1'($urandom_range(0, 1));
      ex_rd = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom_range(0, 1)); mem_memread = 1'($urandom_range(0, 1));
      mem_rd = 5'($urandom_range(0, 3));
      kill = ($urandom_range(0, 15) == 0);
      cmp_zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      bp = id_valid && (id_beq || id_bne) && !kill;
      res = 0; stl = 0;
      if (!bp) begin
        m_pend = 0;
      end else if (!m_pend) begin
        n = 0;
        if (mem_regwrite && mem_memread && reads(mem_rd)) n = 1;
        if (ex_regwrite && !ex_memread && reads(ex_rd)) n = 1;
        if (ex_regwrite && ex_memread && reads(ex_rd)) n = 2;
        if (n == 0) res = 1;
        else begin stl = 1; m_pend = 1; m_left = n - 1; end
      end else if (m_left > 0) begin
        stl = 1; m_left--;
      end else begin
        res = 1; m_pend = 0;
      end
      tk = res && (id_beq ? cmp_zero : !cmp_zero);
      fa = res && mem_regwrite && !mem_memread && mem_rd != 0 && mem_rd == id_rs;
      fb = res && mem_regwrite && !mem_memread && mem_rd != 0 && mem_rd == id_rt;
      exp = {stl, res, fa, fb, tk, tk};
      vectors++;
      if (ctl() !== exp) begin
        miscompares++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, ctl(), exp);
      end
      vectors++;
      if ({br_count, taken_count, stall_count} !== {16'(m_br), 16'(m_tk), 16'(m_st)}) begin
        miscompares++;
        $display("FAIL rand_cnt[%0d]: got %0d %0d %0d want %0d %0d %0d", i,
                 br_count, taken_count, stall_count, m_br, m_tk, m_st);
      end
      m_br += res; m_tk += tk; m_st += stl;
      tick();
    end
    set_idle();
    @(negedge clk);
    vectors++;
    if ({br_count, taken_count, stall_count} !== {16'(m_br), 16'(m_tk), 16'(m_st)}) begin
      miscompares++;
      $display("FAIL rand_cnt_end: got %0d %0d %0d want %0d %0d %0d",
               br_count, taken_count, stall_count, m_br, m_tk, m_st);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_br(1, 5'd1, 5'd2); cmp_zero = 1;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({br_count, taken_count, stall_count} !== {16'hFFFF, 16'hFFFF, 16'd0}) begin
      miscompares++; $display("FAIL sat_cnt: got %h %h %h want ffff ffff 0000", br_count, taken_count, stall_count);
    end
    tick();
    set_ex(1, 1, 5'd2);
    @(negedge clk);
    vectors++;
    if (ctl() !== 6'b100000) begin
      miscompares++; $display("FAIL sat_stall: got %b want 100000", ctl());
    end
    tick();
    set_ex(0, 0, 5'd0);
    #2;
    rst_n = 0;
    #1;
    vectors++;
    if (ctl() !== 6'b000000) begin
      miscompares++; $display("FAIL async_rst_ctl: got %b want 000000", ctl());
    end
    vectors++;
    if ({br_count, taken_count, stall_count} !== 48'd0) begin
      miscompares++; $display("FAIL async_rst_cnt: got %h %h %h want 0", br_count, taken_count, stall_count);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_no_hazard();
    test_alu_hazard();
    test_load_use();
    test_kill_mid_stall();
    test_kill_priority();
    test_r0();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

ID-stage branch resolution controller for the pipelined MIPS core. It sequences the equality comparator for `beq`/`bne`, detects operand hazards against the EX and MEM stages, and stalls the front end for the required number of cycles. It selects comparator operand forwarding, and issues the PC redirect and IF/ID flush on a taken branch. It also keeps saturating branch statistics counters.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: the ID-stage instruction is valid.
- `id_beq` / `id_bne` in 1 each: the ID-stage instruction is beq / bne. At most one is set.
- `id_rs`, `id_rt` in 5 each: branch source registers.
- `ex_regwrite`, `ex_memread` in 1 each; `ex_rd` in 5: destination info of the instruction in EX.
- `mem_regwrite`, `mem_memread` in 1 each; `mem_rd` in 5: destination info of the instruction in MEM.
- `kill` in 1: external flush (exception). Aborts any pending branch.
- `cmp_zero` in 1: comparator result (1 = operands equal). Combinational in the same cycle.
- `cmp_en` out 1: comparator enable / resolve strobe.
- `fwd_a`, `fwd_b` out 1 each: comparator operand select. 0 = register file; 1 = EX/MEM ALU result.
- `stall` out 1: hold PC and IF/ID, and insert a bubble into ID/EX.
- `flush` out 1: squash IF/ID.
- `pc_src` out 1: select the branch target as next PC.
- `br_count`, `taken_count`, `stall_count` out 16 each: saturating statistics.

## Operation
- FSM states: IDLE, STALL, RESOLVE. Reset state is IDLE, with the stall counter `scnt` (2-bit) = 0.
- A branch is present when `id_valid & (id_beq | id_bne) & ~kill`.
- Hazard match means: `rd != 0` and `rd` equals `id_rs` or `id_rt`.
- Required stall count `n` is the maximum of:
  - 2 if EX matches with `ex_regwrite & ex_memread`;
  - 1 if EX matches with `ex_regwrite & ~ex_memread`;
  - 1 if MEM matches with `mem_regwrite & mem_memread`;
  - 0 otherwise.
- IDLE, branch present and `n == 0`: resolve in this cycle (see the resolve rules) and stay in IDLE.
- IDLE, branch present and `n > 0`: assert `stall`, load `scnt <= n-1`, and go to STALL if `n == 2`, else to RESOLVE.
- STALL: assert `stall`, decrement `scnt`, and go to RESOLVE when `scnt == 1` on entry.
- RESOLVE: resolve, then go to IDLE.
- Resolve rules:
  - `cmp_en = 1`.
  - `fwd_a = mem_regwrite & ~mem_memread & mem_rd != 0 & mem_rd == id_rs`. `fwd_b` is the same rule using `id_rt`.
  - taken = `id_beq ? cmp_zero : ~cmp_zero`.
  - `pc_src = flush = taken`.
- MEM/WB hazards are covered by write-first register file behaviour and need no forwarding.
- `kill` in any state forces the next state to IDLE and `scnt` to 0. In that cycle `stall`, `cmp_en`, `pc_src` and `flush` are all 0. Counters do not update.
- Statistics:
  - `br_count` increments once per resolve.
  - `taken_count` increments once per taken resolve.
  - `stall_count` increments per cycle with `stall = 1`.
  - All saturate at 0xFFFF and do not wrap.
- Non-branch instructions: all control outputs are 0 and the FSM stays in IDLE.

## Timing
- `stall`, `cmp_en`, `fwd_*`, `pc_src` and `flush` are combinational (Mealy) from state and inputs. Counters and state are registered.
- Reset values: all outputs are 0, counters are 0, and the state is IDLE. Reset asserted mid-stall aborts immediately (asynchronous).
- Resolve latency from a branch entering ID:
  - 0 cycles for no hazard;
  - 1 cycle for an ALU result in EX or a load in MEM;
  - 2 cycles for a load in EX.
- Taken-branch penalty: 1 cycle (the IF/ID flush) plus any stalls.
- Timing boundary cases:
  - `stall` and `flush` are never both 1.
  - `kill` has priority over resolve in the same cycle.
  - A branch arriving in the cycle after a resolve is evaluated normally; there is no dead cycle.

## Test plan
- No hazard: beq r1,r2 with no matches and `cmp_zero = 1` → in the same cycle `cmp_en = 1`, `pc_src = 1`, `flush = 1`, `stall = 0`; `br_count = 1`, `taken_count = 1`.
- ALU hazard: EX has add r3 (regwrite, rd = 3); bne r3,r4 → `stall = 1` for 1 cycle. The next cycle resolves with `fwd_a = 1`; `cmp_zero = 1` → `pc_src = 0`, `flush = 0`; `stall_count = 1`.
- Load-use: EX has lw r5; beq r0,r5 → `stall = 1` for 2 cycles, then resolves with `fwd_b = 0`; `stall_count = 2`.
- Kill mid-stall: load hazard, `kill = 1` on the second cycle → `stall = 0` in that cycle, the FSM returns to IDLE, and no `br_count` increment.
- r0 destination: EX writes rd = 0 and the branch reads r0 → no stall; resolves immediately.
- Saturation: 65 536 taken resolves → `br_count` and `taken_count` hold at 0xFFFF. Then assert `rst_n = 0` asynchronously → all counters and outputs are 0 before the next clock edge.
